// File: rtl/cache_set_ctrl.sv
// One set of an N-way set-associative cache with tree PLRU replacement and a
// writeback/refill miss handler. Optional hit/miss counters: CACHE_SET_STATS_EN.
module cache_set_ctrl #(
    parameter  int NUM_WAYS   = 4,
    parameter  int TAG_BITS   = 51,
    parameter  int LINE_WORDS = 4,
    parameter  int WORD_WIDTH = 64,
    localparam int WI         = $clog2(LINE_WORDS),
    localparam int LW         = LINE_WORDS * WORD_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [TAG_BITS-1:0]   req_tag_i,
    input  logic [WI-1:0]         req_word_i,
    input  logic [WORD_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic                  resp_hit_o,
    output logic [WORD_WIDTH-1:0] resp_rdata_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [TAG_BITS-1:0]   wb_tag_o,
    output logic [LW-1:0]         wb_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [TAG_BITS-1:0]   mem_req_tag_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [LW-1:0]         mem_rsp_data_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int WB    = $clog2(NUM_WAYS);
    localparam int NIDX  = $clog2(2 * NUM_WAYS - 1);
    localparam int NSPAN = 1 << NIDX;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4,
        S_RESP      = 3'd5
    } state_t;

    // Tree nodes are heap-indexed; padding the bit vector to a power of two
    // lets a node index address it at its natural width.
    function automatic logic [WB-1:0] plru_victim(input logic [NUM_WAYS-2:0] bits);
        logic [NSPAN-1:0] pad;
        logic [NIDX-1:0]  node;
        pad  = NSPAN'(bits);
        node = '0;
        for (int l = 0; l < WB; l++) begin
            node = (node << 1) + NIDX'(1) + NIDX'(pad[node]);
        end
        return WB'(node - NIDX'(NUM_WAYS - 1));
    endfunction

    // Left children have odd indices, so node[0] is exactly the "point away" value.
    function automatic logic [NUM_WAYS-2:0] plru_touch(input logic [NUM_WAYS-2:0] bits,
                                                       input logic [WB-1:0]       way);
        logic [NSPAN-1:0] pad;
        logic [NIDX-1:0]  node;
        logic [NIDX-1:0]  parent;
        pad  = NSPAN'(bits);
        node = NIDX'(way) + NIDX'(NUM_WAYS - 1);
        for (int l = 0; l < WB; l++) begin
            parent      = (node - NIDX'(1)) >> 1;
            pad[parent] = node[0];
            node        = parent;
        end
        return pad[NUM_WAYS-2:0];
    endfunction

    state_t                state_q, state_d;
    logic [TAG_BITS-1:0]   tag_q   [NUM_WAYS];
    logic [TAG_BITS-1:0]   tag_d   [NUM_WAYS];
    logic [WORD_WIDTH-1:0] data_q  [NUM_WAYS][LINE_WORDS];
    logic [WORD_WIDTH-1:0] data_d  [NUM_WAYS][LINE_WORDS];
    logic [NUM_WAYS-1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [NUM_WAYS-2:0]   plru_q, plru_d;
    logic                  req_write_q, req_write_d;
    logic [TAG_BITS-1:0]   req_tag_q, req_tag_d;
    logic [WI-1:0]         req_word_q, req_word_d;
    logic [WORD_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [WB-1:0]         victim_q, victim_d;
    logic                  resp_hit_q, resp_hit_d;
    logic [WORD_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [NUM_WAYS-1:0]   hit_vec;
    logic                  hit_any;
    logic [WB-1:0]         hit_way, inv_way, victim_sel;
    logic [WORD_WIDTH-1:0] fill_word [LINE_WORDS];

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_ways
        assign hit_vec[g] = valid_q[g] && (tag_q[g] == req_tag_q);
    end

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_words
        assign fill_word[k]                          = mem_rsp_data_i[k*WORD_WIDTH +: WORD_WIDTH];
        assign wb_data_o[k*WORD_WIDTH +: WORD_WIDTH] = data_q[victim_q][k];
    end

    // Hit encoding and victim choice: lowest invalid way first, else the PLRU leaf.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_way = hit_vec[w] ? WB'(w) : hit_way;
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            inv_way = valid_q[w] ? inv_way : WB'(w);
        end
        hit_any    = |hit_vec;
        victim_sel = (&valid_q) ? plru_victim(plru_q) : inv_way;
    end

    // Controller next state and storage updates.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        data_d       = data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        req_write_d  = req_write_q;
        req_tag_d    = req_tag_q;
        req_word_d   = req_word_q;
        req_wdata_d  = req_wdata_q;
        victim_d     = victim_q;
        resp_hit_d   = resp_hit_q;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    req_write_d = req_write_i;
                    req_tag_d   = req_tag_i;
                    req_word_d  = req_word_i;
                    req_wdata_d = req_wdata_i;
                    state_d     = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    if (req_write_q) begin
                        data_d[hit_way][req_word_q] = req_wdata_q;
                        dirty_d[hit_way]            = 1'b1;
                        resp_rdata_d                = '0;
                    end else begin
                        resp_rdata_d = data_q[hit_way][req_word_q];
                    end
                    plru_d     = plru_touch(plru_q, hit_way);
                    resp_hit_d = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    victim_d   = victim_sel;
                    resp_hit_d = 1'b0;
                    state_d    = (valid_q[victim_sel] && dirty_q[victim_sel]) ? S_WRITEBACK
                                                                               : S_FILL_REQ;
                end
            end
            S_WRITEBACK: begin
                state_d = wb_ready_i ? S_FILL_REQ : S_WRITEBACK;
            end
            S_FILL_REQ: begin
                state_d = mem_req_ready_i ? S_FILL_WAIT : S_FILL_REQ;
            end
            S_FILL_WAIT: begin
                if (mem_rsp_valid_i) begin
                    data_d[victim_q]  = fill_word;
                    tag_d[victim_q]   = req_tag_q;
                    valid_d[victim_q] = 1'b1;
                    if (req_write_q) begin
                        data_d[victim_q][req_word_q] = req_wdata_q;
                        dirty_d[victim_q]            = 1'b1;
                        resp_rdata_d                 = '0;
                    end else begin
                        dirty_d[victim_q] = 1'b0;
                        resp_rdata_d      = fill_word[req_word_q];
                    end
                    plru_d  = plru_touch(plru_q, victim_q);
                    state_d = S_RESP;
                end else begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_RESP: begin
                state_d = resp_ready_i ? S_IDLE : S_RESP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and storage registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q      <= S_IDLE;
            tag_q        <= '{default: '0};
            data_q       <= '{default: '0};
            valid_q      <= '0;
            dirty_q      <= '0;
            plru_q       <= '0;
            req_write_q  <= 1'b0;
            req_tag_q    <= '0;
            req_word_q   <= '0;
            req_wdata_q  <= '0;
            victim_q     <= '0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            plru_q       <= plru_d;
            req_write_q  <= req_write_d;
            req_tag_q    <= req_tag_d;
            req_word_q   <= req_word_d;
            req_wdata_q  <= req_wdata_d;
            victim_q     <= victim_d;
            resp_hit_q   <= resp_hit_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign resp_valid_o    = (state_q == S_RESP);
    assign wb_valid_o      = (state_q == S_WRITEBACK);
    assign mem_req_valid_o = (state_q == S_FILL_REQ);
    assign wb_tag_o        = tag_q[victim_q];
    assign mem_req_tag_o   = req_tag_q;
    assign resp_hit_o      = resp_hit_q;
    assign resp_rdata_o    = resp_rdata_q;

`ifdef CACHE_SET_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    // Saturating lookup statistics.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == S_LOOKUP) begin
            if (hit_any) begin
                hit_cnt_d = (hit_cnt_q == 32'hFFFF_FFFF) ? hit_cnt_q : hit_cnt_q + 32'd1;
            end else begin
                miss_cnt_d = (miss_cnt_q == 32'hFFFF_FFFF) ? miss_cnt_q : miss_cnt_q + 32'd1;
            end
        end else begin
            hit_cnt_d  = hit_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = 32'd0;
    assign miss_count_o = 32'd0;
`endif

endmodule
